// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encoding, FSM states, iteration counts.
package hilo_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV     = 2'd2,
        ST_DIV_FIX = 2'd3
    } md_state_t;

    localparam int MD_DIV_ITERS = 32;
    localparam int MD_CNT_W     = 6;

    function automatic logic is_mul(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_muldiv(input md_op_t op);
        return is_mul(op) || is_div(op);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the execute stage and the HI/LO mul/div unit.
interface hilo_muldiv_unit_if;
    import hilo_muldiv_unit_pkg::*;

    logic        start;
    md_op_t      op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/hilo_muldiv_unit_serial_divider.sv
// Unsigned radix-2 restoring divider: the start edge performs iteration 1, then one quotient bit per
// cycle; o_valid holds once all iterations are done until the next start. No backpressure.
module serial_divider
    import hilo_muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_q,
    output logic [31:0] o_r,
    output logic        o_valid
);
    localparam logic [MD_CNT_W-1:0] ITERS = MD_CNT_W'(MD_DIV_ITERS);

    logic [31:0]         r_rem;
    logic [31:0]         r_quo;
    logic [31:0]         r_dvs;
    logic [MD_CNT_W-1:0] r_iter;

    logic [31:0] w_rem_src;
    logic [31:0] w_quo_src;
    logic [31:0] w_dvs_src;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_step;

    // Loading and the first iteration share the start edge, so the source mux feeds the datapath.
    always_comb begin
        w_rem_src = i_start ? 32'd0 : r_rem;
        w_quo_src = i_start ? i_a   : r_quo;
        w_dvs_src = i_start ? i_b   : r_dvs;
        w_shift   = {w_rem_src, w_quo_src[31]};
        w_trial   = w_shift - {1'b0, w_dvs_src};
        w_step    = i_start || ((r_iter != '0) && (r_iter < ITERS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_iter <= '0;
        end else if (w_step) begin
            // Partial remainder stays below the divisor, so 32 bits always hold it.
            r_rem  <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
            r_quo  <= {w_quo_src[30:0], ~w_trial[32]};
            r_dvs  <= w_dvs_src;
            r_iter <= i_start ? MD_CNT_W'(1) : r_iter + 1'b1;
        end
    end

    assign o_q     = r_quo;
    assign o_r     = r_rem;
    assign o_valid = (r_iter == ITERS);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MTHI/MTLO: mul result MUL_LATENCY edges after accept,
// div result 33 edges after accept, MT* next edge; busy stalls the pipe, cancel aborts.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_unit_if.slave md_bus
);
    localparam logic [MD_CNT_W-1:0] MUL_LAST = MD_CNT_W'(MUL_LATENCY - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LAST = MD_CNT_W'(MD_DIV_ITERS - 1);

    md_state_t           r_state;
    md_state_t           w_state_nxt;
    logic [MD_CNT_W-1:0] r_cnt;
    logic [63:0]         r_prod;
    logic                r_q_neg;
    logic                r_r_neg;
    logic                r_div_zero;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic                r_done;

    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic [63:0]        w_prod;
    logic               w_accept;
    logic               w_accept_md;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [31:0]        w_div_a;
    logic [31:0]        w_div_b;
    logic               w_div_start;
    logic [31:0]        w_div_q;
    logic [31:0]        w_div_r;
    logic               w_div_valid;
    logic [31:0]        w_q_fix;
    logic [31:0]        w_r_fix;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic               w_done_nxt;

    assign w_accept    = (r_state == ST_IDLE) && md_bus.start && !md_bus.cancel;
    assign w_accept_md = w_accept && is_muldiv(md_bus.op);

    always_comb begin
        w_a_sx = {{32{md_bus.rs_data[31]}}, md_bus.rs_data};
        w_b_sx = {{32{md_bus.rt_data[31]}}, md_bus.rt_data};
        if (md_bus.op == MD_MULT) begin
            w_prod = $unsigned(w_a_sx * w_b_sx);
        end else begin
            w_prod = {32'd0, md_bus.rs_data} * {32'd0, md_bus.rt_data};
        end
    end

    // The divider only sees magnitudes; signs are reapplied in DIV_FIX.
    assign w_a_neg = (md_bus.op == MD_DIV) && md_bus.rs_data[31];
    assign w_b_neg = (md_bus.op == MD_DIV) && md_bus.rt_data[31];
    assign w_div_a = w_a_neg ? (32'd0 - md_bus.rs_data) : md_bus.rs_data;
    assign w_div_b = w_b_neg ? (32'd0 - md_bus.rt_data) : md_bus.rt_data;

    serial_divider u_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_div_start),
        .i_a     (w_div_a),
        .i_b     (w_div_b),
        .o_q     (w_div_q),
        .o_r     (w_div_r),
        .o_valid (w_div_valid)
    );

    assign w_q_fix = r_q_neg ? (32'd0 - w_div_q) : w_div_q;
    assign w_r_fix = r_r_neg ? (32'd0 - w_div_r) : w_div_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_mul(md_bus.op)) begin
                        // Single-cycle multiply writes straight from the accept edge.
                        if (MUL_LATENCY == 1) begin
                            w_wr_hi    = 1'b1;
                            w_wr_lo    = 1'b1;
                            w_hi_nxt   = w_prod[63:32];
                            w_lo_nxt   = w_prod[31:0];
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_MUL;
                        end
                    end else if (is_div(md_bus.op)) begin
                        w_state_nxt = ST_DIV;
                        w_div_start = 1'b1;
                    end else if (md_bus.op == MD_MTHI) begin
                        w_wr_hi  = 1'b1;
                        w_hi_nxt = md_bus.rs_data;
                    end else if (md_bus.op == MD_MTLO) begin
                        w_wr_lo  = 1'b1;
                        w_lo_nxt = md_bus.rs_data;
                    end
                end
            end
            ST_MUL: begin
                if (md_bus.cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == MUL_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_wr_hi     = 1'b1;
                    w_wr_lo     = 1'b1;
                    w_hi_nxt    = r_prod[63:32];
                    w_lo_nxt    = r_prod[31:0];
                    w_done_nxt  = 1'b1;
                end
            end
            ST_DIV: begin
                if (md_bus.cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == DIV_LAST) begin
                    w_state_nxt = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                w_state_nxt = ST_IDLE;
                if (!md_bus.cancel && w_div_valid) begin
                    w_wr_hi    = 1'b1;
                    w_wr_lo    = 1'b1;
                    w_hi_nxt   = w_r_fix;
                    w_lo_nxt   = r_div_zero ? 32'hFFFF_FFFF : w_q_fix;
                    w_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_cnt counts edges since accept, the accept edge being 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_prod     <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_accept_md) begin
                r_cnt      <= MD_CNT_W'(1);
                r_prod     <= w_prod;
                r_q_neg    <= w_a_neg ^ w_b_neg;
                r_r_neg    <= w_a_neg;
                r_div_zero <= (md_bus.rt_data == 32'd0);
            end else if ((r_state == ST_MUL) || (r_state == ST_DIV)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_wr_hi) begin
                r_hi <= w_hi_nxt;
            end
            if (w_wr_lo) begin
                r_lo <= w_lo_nxt;
            end
        end
    end

    assign md_bus.busy = (r_state != ST_IDLE) || (md_bus.start && is_muldiv(md_bus.op));
    assign md_bus.done = r_done;
    assign md_bus.hi   = r_hi;
    assign md_bus.lo   = r_lo;

endmodule
